// File: rtl/sim_uart_pkg.sv
// Shared definitions for the simulation UART arbiter: newline code, arbiter states and the
// round-robin search helper.
package sim_uart_pkg;

  localparam logic [7:0] CH_NEWLINE = 8'h0A;

  // rr_pick works on a fixed-width mask, so NUM_SRC is limited to MaxSrc
  localparam int unsigned MaxSrc  = 32;
  localparam int unsigned SrcIdxW = 5;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // First set bit of mask[n-1:0], searching ptr, ptr+1, ... modulo n
  function automatic logic [SrcIdxW-1:0] rr_pick(input logic [MaxSrc-1:0]  mask,
                                                 input logic [SrcIdxW-1:0] ptr,
                                                 input int unsigned        n);
    logic                found;
    logic [SrcIdxW-1:0]  idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MaxSrc; i++) begin
      if (i < n) begin
        idx = SrcIdxW'((32'(ptr) + i) % n);
        if (!found && mask[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/sim_uart_arbiter_if.sv
// Console-source and UART-side signals of the simulation UART arbiter.
interface sim_uart_arbiter_if #(
  parameter int unsigned NUM_SRC = 2
);

  logic [NUM_SRC-1:0]   in_valid;
  logic [8*NUM_SRC-1:0] in_ch;
  logic                 uart_valid;
  logic [7:0]           uart_ch;
  logic [NUM_SRC-1:0]   overflow;
  logic                 busy;

  modport master (
    output in_valid, in_ch,
    input  uart_valid, uart_ch, overflow, busy
  );

  modport slave (
    input  in_valid, in_ch,
    output uart_valid, uart_ch, overflow, busy
  );

endinterface

// File: rtl/sim_uart_fifo.sv
// Per-source character FIFO. A push into a full FIFO is accepted only if a pop frees a slot in
// the same cycle; otherwise it is dropped and 'drop' is raised for that cycle.
module sim_uart_fifo #(
  parameter int unsigned BUF_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic       empty,
  output logic [7:0] head,
  output logic       drop
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);

  logic [7:0]      mem [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW:0]   count;
  logic            full;
  logic            wr_en;
  logic            rd_en;

  assign empty = (count == '0);
  assign full  = (count == (PtrW + 1)'(BUF_DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && full && !rd_en;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sim_uart_arbiter.sv
// Line-locking round-robin arbiter sharing the simulation UART among NUM_SRC console sources;
// a source keeps the channel until it emits a newline or stays idle for LOCK_TIMEOUT cycles.
module sim_uart_arbiter
  import sim_uart_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned BUF_DEPTH    = 16,
  parameter int unsigned LOCK_TIMEOUT = 256
) (
  input logic               clock,
  input logic               reset,
  sim_uart_arbiter_if.slave bus
);

  localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CntW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);

  arb_state_e         state;
  logic [SrcW-1:0]    rr_ptr;
  logic [SrcW-1:0]    owner;
  logic [CntW-1:0]    idle_cnt;
  logic               uart_valid;
  logic [7:0]         uart_ch;
  logic [NUM_SRC-1:0] overflow;

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] drop;
  logic [NUM_SRC-1:0] pop;
  logic [7:0]         head [NUM_SRC];
  logic [7:0]         owner_head;
  logic               pop_any;
  logic [SrcW-1:0]    pick;
  logic [SrcW-1:0]    next_ptr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sim_uart_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (bus.in_valid[i]),
      .pop   (pop[i]),
      .wdata (bus.in_ch[8*i +: 8]),
      .empty (empty[i]),
      .head  (head[i]),
      .drop  (drop[i])
    );
  end

  always_comb begin
    pop        = '0;
    owner_head = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (owner == SrcW'(i)) begin
        owner_head = head[i];
        pop[i]     = (state == ARB_LOCKED) && !empty[i];
      end
    end
    pop_any  = |pop;
    pick     = SrcW'(rr_pick(MaxSrc'(~empty), SrcIdxW'(rr_ptr), NUM_SRC));
    next_ptr = (owner == SrcW'(NUM_SRC - 1)) ? '0 : owner + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      idle_cnt   <= '0;
      uart_valid <= 1'b0;
      uart_ch    <= 8'h00;
      overflow   <= '0;
    end else begin
      overflow   <= overflow | drop;
      uart_valid <= pop_any;
      if (pop_any) uart_ch <= owner_head;
      unique case (state)
        ARB_IDLE: begin
          if (!(&empty)) begin
            owner    <= pick;
            idle_cnt <= '0;
            state    <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (pop_any) begin
            idle_cnt <= '0;
            if (owner_head == CH_NEWLINE) begin
              state  <= ARB_IDLE;
              rr_ptr <= next_ptr;
            end
          end else begin
            if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
            // Idle check uses the pre-increment count
            if (LOCK_TIMEOUT != 0 && idle_cnt == TimeoutLast) begin
              state  <= ARB_IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.uart_valid = uart_valid;
  assign bus.uart_ch    = uart_ch;
  assign bus.overflow   = overflow;
  assign bus.busy       = !(&empty) || (state == ARB_LOCKED);

endmodule

// File: tb/tb_sim_uart_arbiter.sv
// Directed bench for sim_uart_arbiter: two sources, 16-deep FIFOs, lock timeout of 8 cycles.
module tb_sim_uart_arbiter;

  typedef struct {
    int         cyc;
    logic [7:0] ch;
  } ev_t;

  logic clock;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  ev_t  out_q[$];

  sim_uart_arbiter_if #(.NUM_SRC(2)) bus ();

  sim_uart_arbiter #(
    .NUM_SRC      (2),
    .BUF_DEPTH    (16),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.uart_valid) out_q.push_back('{cyc: cyc, ch: bus.uart_ch});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic drive(input logic v0, input byte c0, input logic v1, input byte c1);
    bus.in_valid = {v1, v0};
    bus.in_ch    = {c1, c0};
    step();
  endtask

  task automatic send_pair(input string s0, input string s1);
    int n;
    n = (s0.len() > s1.len()) ? s0.len() : s1.len();
    for (int i = 0; i < n; i++) begin
      drive(i < s0.len(), (i < s0.len()) ? s0[i] : 8'h00,
            i < s1.len(), (i < s1.len()) ? s1[i] : 8'h00);
    end
    bus.in_valid = '0;
  endtask

  task automatic do_reset();
    bus.in_valid = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    out_q.delete();
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clock);
    while (bus.busy && n < bound) begin
      @(negedge clock);
      n++;
    end
    check_eq("drain_busy", 32'(bus.busy), 32'd0);
    repeat (3) step();
  endtask

  task automatic check_text(input string tag, input int base, input string exp);
    for (int i = 0; i < exp.len(); i++) begin
      check_eq(tag, 32'(out_q[base + i].ch), 32'(exp[i]));
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.in_valid = '0;
    bus.in_ch    = '0;

    // Reset state
    step();
    step();
    @(negedge clock);
    check_eq("rst_uart_valid", 32'(bus.uart_valid), 32'd0);
    check_eq("rst_uart_ch",    32'(bus.uart_ch),    32'h00);
    check_eq("rst_overflow",   32'(bus.overflow),   32'd0);
    check_eq("rst_busy",       32'(bus.busy),       32'd0);
    step();
    reset = 1'b0;
    out_q.delete();

    // 1: single source, latency and busy
    go_to(10);
    send_pair("ok\n", "");
    go_to(14);
    @(negedge clock);
    check_eq("t1_busy_14", 32'(bus.busy), 32'd1);
    go_to(16);
    @(negedge clock);
    check_eq("t1_busy_16", 32'(bus.busy), 32'd0);
    check_eq("t1_count", 32'(out_q.size()), 32'd3);
    check_eq("t1_cyc0", 32'(out_q[0].cyc), 32'd13);
    check_eq("t1_cyc1", 32'(out_q[1].cyc), 32'd14);
    check_eq("t1_cyc2", 32'(out_q[2].cyc), 32'd15);
    check_text("t1_text", 0, "ok\n");

    // 2: simultaneous lines are not mixed; one idle cycle between lines
    do_reset();
    send_pair("AB\n", "xy\n");
    wait_idle(100);
    check_eq("t2_count", 32'(out_q.size()), 32'd6);
    check_text("t2_text", 0, "AB\nxy\n");
    check_eq("t2_gap", 32'(out_q[3].cyc - out_q[2].cyc), 32'd2);
    check_eq("t2_line", 32'(out_q[2].cyc - out_q[0].cyc), 32'd2);

    // 3: fairness alternates starting with src0
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i % 2) ? 8'h0A : "a", 1'b1, (i % 2) ? 8'h0A : "b");
    end
    bus.in_valid = '0;
    wait_idle(200);
    check_eq("t3_count", 32'(out_q.size()), 32'd24);
    check_text("t3_text", 0, "a\nb\na\nb\na\nb\na\nb\na\nb\na\nb\n");

    // 4: src1 overflows while src0 holds the lock
    do_reset();
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, (i == 30) ? 8'h0A : ".", (i >= 3 && i < 23), 8'(8'h41 + i - 3));
    end
    bus.in_valid = '0;
    wait_idle(300);
    check_eq("t4_overflow", 32'(bus.overflow), 32'b10);
    check_eq("t4_count", 32'(out_q.size()), 32'd47);
    check_eq("t4_src0_nl", 32'(out_q[30].ch), 32'h0A);
    check_text("t4_src1", 31, "ABCDEFGHIJKLMNOP");

    // 5: timeout releases an owner that never ends its line
    do_reset();
    send_pair("abc", "z\n");
    wait_idle(200);
    check_eq("t5_count", 32'(out_q.size()), 32'd5);
    check_text("t5_text", 0, "abcz\n");
    check_eq("t5_gap", 32'(out_q[3].cyc - out_q[2].cyc), 32'd10);

    // 6: reset while characters are buffered
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, ".", 1'b1, 8'(8'h31 + i));
    bus.in_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check_eq("t6_uart_valid", 32'(bus.uart_valid), 32'd0);
    check_eq("t6_busy",       32'(bus.busy),       32'd0);
    check_eq("t6_overflow",   32'(bus.overflow),   32'd0);
    step();
    out_q.delete();
    send_pair("", "hi\n");
    wait_idle(100);
    check_eq("t6_count", 32'(out_q.size()), 32'd3);
    check_text("t6_text", 0, "hi\n");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
